// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Request/result bundle between a client and bcd_seq_converter.
interface bcd_seq_converter_if
  import bcd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
);

  logic                             start;
  logic                             signed_mode;
  logic [WIDTH-1:0]                 bin_in;
  logic                             busy;
  logic                             done;
  logic                             sign_out;
  logic [BCD_DIGIT_W*DIGITS-1:0]    bcd_out;
  logic [DIGITS-1:0]                digit_en;

  modport master (
    output start, signed_mode, bin_in,
    input  busy, done, sign_out, bcd_out, digit_en
  );

  modport slave (
    input  start, signed_mode, bin_in,
    output busy, done, sign_out, bcd_out, digit_en
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Single double-dabble cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = digit;
    if (digit >= ADJ_THRESH) adjusted = digit + ADJ_ADD;
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter, one double-dabble shift per clock.
// Optional leading-zero blanking on digit_en is enabled by defining BCD_LZ_BLANK_EN.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input logic                clk,
  input logic                rst,
  bcd_seq_converter_if.slave bus
);

  localparam int                BCD_W    = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   mag;
  logic [BCD_W-1:0]   bcd_work;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [BCD_W-1:0]   bcd_out_r;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic               neg_in;
  logic               sign_r;
  logic               last_shift;
  logic               busy_c;
  logic               done_c;

  assign neg_in     = bus.signed_mode & bus.bin_in[WIDTH-1];
  assign mag        = neg_in ? (~bus.bin_in + WIDTH'(1)) : bus.bin_in;
  assign last_shift = (cnt == LAST_CNT);

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (bcd_adj [g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Top bit of the adjusted row falls off; 10^DIGITS > 2^WIDTH keeps it zero.
  assign bcd_next = BCD_W'({bcd_adj, shift_reg[WIDTH-1]});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CONV;
      CONV:    if (last_shift) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      CONV: busy_c = 1'b1;
      DONE: begin
        busy_c = 1'b1;
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bcd_work  <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      bcd_out_r <= '0;
      sign_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          shift_reg <= mag;
          bcd_work  <= '0;
          cnt       <= '0;
          neg       <= neg_in;
        end
        CONV: begin
          shift_reg <= shift_reg << 1;
          bcd_work  <= bcd_next;
          cnt       <= cnt + CNT_W'(1);
          if (last_shift) begin
            bcd_out_r <= bcd_next;
            sign_r    <= neg;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] digit_en_next;
  logic [DIGITS-1:0] digit_en_r;
  logic              seen_nz;

  // Scan from the most significant digit down; ones digit always lit.
  always_comb begin
    digit_en_next = '0;
    seen_nz       = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      seen_nz = seen_nz |
                (bcd_next[(DIGITS-1-i)*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
      digit_en_next[DIGITS-1-i] = seen_nz;
    end
    digit_en_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                              digit_en_r <= '1;
    else if (state == CONV && last_shift) digit_en_r <= digit_en_next;
  end

  assign bus.digit_en = digit_en_r;
`else
  assign bus.digit_en = '1;
`endif

  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.bcd_out  = bcd_out_r;
  assign bus.sign_out = sign_r;

endmodule
